// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit core: instruction classes, comparator codes,
// PC-select values and the sequencer state type.
package cpu_pkg;

    localparam logic [1:0] CLS_MEM = 2'b00;
    localparam logic [1:0] CLS_ALU = 2'b01;
    localparam logic [1:0] CLS_BR  = 2'b10;
    localparam logic [1:0] CLS_RSV = 2'b11;

    localparam logic [2:0] CMP_JMP = 3'b110;
    localparam logic [2:0] CMP_NOP = 3'b111;

    localparam logic PC_SEL_INC = 1'b0;
    localparam logic PC_SEL_JMP = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_e;

    // Unconditional jump always takes, NOP never does, everything else follows the comparator.
    function automatic logic branch_taken(input logic [2:0] cmp_ctrl, input logic cmp_true);
        logic taken;
        if (cmp_ctrl == CMP_JMP) begin
            taken = 1'b1;
        end else if (cmp_ctrl == CMP_NOP) begin
            taken = 1'b0;
        end else begin
            taken = cmp_true;
        end
        return taken;
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Shared memory port between the sequencer (master) and the memory system (slave).
interface cpu_sequencer_if;

    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        output mem_ready
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts unacknowledged memory request cycles and flags a bus timeout.
module mem_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic ready,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Every entry into FETCH or MEM comes from a non-request cycle or an acknowledged one,
    // so clearing on either condition restarts the count for each access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!req || ready) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // An acknowledge in the same cycle the limit is reached still completes the access.
    assign expired = (TIMEOUT != 0) && req && !ready && (cnt == CW'(TIMEOUT));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: fetch, decode, execute, memory, writeback around the shared
// memory port, with a bus timeout and a retired-instruction counter.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [1:0]       instr_class,
    input  logic             dec_mem_write,
    input  logic             dec_reg_write,
    input  logic [2:0]       cmp_ctrl,
    input  logic             cmp_true,
    cpu_sequencer_if.master  mem,
    output logic             ir_load,
    output logic             mdr_load,
    output logic             rf_we,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             halted,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);

    state_e state;
    logic   req;
    logic   we;
    logic   addr_sel;
    logic   ready;
    logic   expired;

    assign ready = mem.mem_ready;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .ready   (ready),
        .expired (expired)
    );

    // Strobes depend on the live acknowledge so a zero-wait access finishes in one cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        req      = 1'b0;
        we       = 1'b0;
        addr_sel = 1'b0;
        ir_load  = 1'b0;
        mdr_load = 1'b0;
        rf_we    = 1'b0;
        pc_en    = 1'b0;
        pc_sel   = PC_SEL_INC;
        case (state)
            ST_FETCH: begin
                req     = 1'b1;
                ir_load = ready;
            end
            ST_EXEC: begin
                if (instr_class == CLS_BR) begin
                    pc_en  = 1'b1;
                    pc_sel = branch_taken(cmp_ctrl, cmp_true) ? PC_SEL_JMP : PC_SEL_INC;
                end
            end
            ST_MEM: begin
                req      = 1'b1;
                addr_sel = 1'b1;
                we       = dec_mem_write;
                if (ready) begin
                    mdr_load = !dec_mem_write;
                    pc_en    = dec_mem_write;
                end
            end
            ST_WB: begin
                rf_we = dec_reg_write;
                pc_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem.mem_req      = req;
    assign mem.mem_we       = we;
    assign mem.mem_addr_sel = addr_sel;
    assign halted           = (state == ST_HALT);

    // NOTE: state and counters use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            retired <= '0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            // Every pc_en marks the last cycle of an instruction.
            if (pc_en) begin
                retired <= retired + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (ready) begin
                        state <= ST_DECODE;
                    end else if (expired) begin
                        bus_err <= 1'b1;
                        state   <= ST_HALT;
                    end
                end
                ST_DECODE: state <= ST_EXEC;
                ST_EXEC: begin
                    case (instr_class)
                        CLS_MEM: state <= ST_MEM;
                        CLS_ALU: state <= ST_WB;
                        CLS_BR:  state <= ST_FETCH;
                        CLS_RSV: begin
                            illegal <= 1'b1;
                            state   <= ST_HALT;
                        end
                        default: state <= ST_HALT;
                    endcase
                end
                ST_MEM: begin
                    if (ready) begin
                        state <= dec_mem_write ? ST_FETCH : ST_WB;
                    end else if (expired) begin
                        bus_err <= 1'b1;
                        state   <= ST_HALT;
                    end
                end
                ST_WB:   state <= ST_FETCH;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios plus randomized programs checked cycle by cycle
// against an instruction-level timeline model.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    localparam int TO = 4;
    localparam int CW = 4;

    typedef struct packed {
        logic       run;
        logic [1:0] cls;
        logic       mw;
        logic       rw;
        logic [2:0] cmp;
        logic       ct;
        logic       ready;
    } in_t;

    typedef struct packed {
        logic          mem_req;
        logic          mem_we;
        logic          mem_addr_sel;
        logic          ir_load;
        logic          mdr_load;
        logic          rf_we;
        logic          pc_en;
        logic          pc_sel;
        logic          halted;
        logic          illegal;
        logic          bus_err;
        logic [CW-1:0] retired;
    } out_t;

    typedef struct packed {
        logic [1:0] cls;
        logic       mw;
        logic       rw;
        logic [2:0] cmp;
        logic       ct;
    } instr_t;

    logic          clk;
    logic          rst_n;
    logic          run;
    logic [1:0]    instr_class;
    logic          dec_mem_write;
    logic          dec_reg_write;
    logic [2:0]    cmp_ctrl;
    logic          cmp_true;
    logic          ir_load;
    logic          mdr_load;
    logic          rf_we;
    logic          pc_en;
    logic          pc_sel;
    logic          halted;
    logic          illegal;
    logic          bus_err;
    logic [CW-1:0] retired;

    cpu_sequencer_if bus();

    cpu_sequencer #(
        .TIMEOUT (TO),
        .CNT_W   (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .instr_class   (instr_class),
        .dec_mem_write (dec_mem_write),
        .dec_reg_write (dec_reg_write),
        .cmp_ctrl      (cmp_ctrl),
        .cmp_true      (cmp_true),
        .mem           (bus),
        .ir_load       (ir_load),
        .mdr_load      (mdr_load),
        .rf_we         (rf_we),
        .pc_en         (pc_en),
        .pc_sel        (pc_sel),
        .halted        (halted),
        .illegal       (illegal),
        .bus_err       (bus_err),
        .retired       (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    int   m_ret;
    bit   m_ill;
    bit   m_berr;
    out_t last;

    function automatic out_t sample();
        out_t s;
        s.mem_req      = bus.mem_req;
        s.mem_we       = bus.mem_we;
        s.mem_addr_sel = bus.mem_addr_sel;
        s.ir_load      = ir_load;
        s.mdr_load     = mdr_load;
        s.rf_we        = rf_we;
        s.pc_en        = pc_en;
        s.pc_sel       = pc_sel;
        s.halted       = halted;
        s.illegal      = illegal;
        s.bus_err      = bus_err;
        s.retired      = retired;
        return s;
    endfunction

    task automatic drive(input in_t i);
        run           = i.run;
        instr_class   = i.cls;
        dec_mem_write = i.mw;
        dec_reg_write = i.rw;
        cmp_ctrl      = i.cmp;
        cmp_true      = i.ct;
        bus.mem_ready = i.ready;
    endtask

    function automatic in_t rnd_in();
        in_t i;
        i.run   = 1'($urandom);
        i.cls   = 2'($urandom);
        i.mw    = 1'($urandom);
        i.rw    = 1'($urandom);
        i.cmp   = 3'($urandom);
        i.ct    = 1'($urandom);
        i.ready = 1'($urandom);
        return i;
    endfunction

    function automatic in_t with_ins(input instr_t ins);
        in_t i;
        i     = rnd_in();
        i.cls = ins.cls;
        i.mw  = ins.mw;
        i.rw  = ins.rw;
        i.cmp = ins.cmp;
        i.ct  = ins.ct;
        return i;
    endfunction

    // Expected outputs of a cycle with no strobes: only the sticky flags and the count show.
    function automatic out_t base();
        out_t e;
        e         = '0;
        e.illegal = m_ill;
        e.bus_err = m_berr;
        e.retired = CW'(m_ret);
        return e;
    endfunction

    // Branch rule: 110 always jumps, 111 never does, any other code follows cmp_true.
    function automatic logic br_model(input logic [2:0] cmp, input logic ct);
        if (cmp == 3'b110) return 1'b1;
        if (cmp == 3'b111) return 1'b0;
        return ct;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One clock: drive at posedge+1, compare at negedge, return at next posedge+1.
    task automatic cyc(input string name, input in_t i, input out_t e);
        drive(i);
        @(negedge clk);
        last = sample();
        n_vec++;
        if (last !== e) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, last, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_t z;
        z     = '0;
        rst_n = 1'b0;
        drive(z);
        #1;
        check("reset_outputs", 32'(sample()), 32'd0);
        m_ret  = 0;
        m_ill  = 1'b0;
        m_berr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int idle_n);
        in_t i;
        for (int k = 0; k < idle_n; k++) begin
            i     = rnd_in();
            i.run = 1'b0;
            cyc("idle", i, base());
        end
        i     = rnd_in();
        i.run = 1'b1;
        cyc("idle_run", i, base());
    endtask

    // A fetch (data=0) or data access (data=1): `waits` unacknowledged cycles, then either
    // the acknowledge or, when expire is set, one more silent cycle that trips the timeout.
    task automatic t_bus(input bit data, input instr_t ins, input int waits, input bit expire);
        in_t   i;
        out_t  e;
        string nm;
        nm = data ? "mem" : "fetch";
        for (int w = 0; w <= waits; w++) begin
            i              = data ? with_ins(ins) : rnd_in();
            i.ready        = (w == waits) && !expire;
            e              = base();
            e.mem_req      = 1'b1;
            e.mem_addr_sel = data;
            e.mem_we       = data & ins.mw;
            if (i.ready) begin
                if (!data) begin
                    e.ir_load = 1'b1;
                end else if (ins.mw) begin
                    e.pc_en = 1'b1;
                end else begin
                    e.mdr_load = 1'b1;
                end
            end
            cyc(nm, i, e);
            if (i.ready && data && ins.mw) m_ret++;
        end
        if (expire) m_berr = 1'b1;
    endtask

    task automatic t_halt(input int n);
        out_t e;
        for (int k = 0; k < n; k++) begin
            e        = base();
            e.halted = 1'b1;
            cyc("halt", rnd_in(), e);
        end
    endtask

    task automatic t_decode(input instr_t ins);
        cyc("decode", with_ins(ins), base());
    endtask

    task automatic t_exec(input instr_t ins);
        out_t e;
        e = base();
        if (ins.cls == CLS_BR) begin
            e.pc_en  = 1'b1;
            e.pc_sel = br_model(ins.cmp, ins.ct);
        end
        cyc("exec", with_ins(ins), e);
        if (ins.cls == CLS_BR) m_ret++;
        if (ins.cls == CLS_RSV) m_ill = 1'b1;
    endtask

    task automatic t_wb(input instr_t ins);
        out_t e;
        e       = base();
        e.rf_we = ins.rw;
        e.pc_en = 1'b1;
        cyc("wb", with_ins(ins), e);
        m_ret++;
    endtask

    task automatic t_instr(input instr_t ins, input int fw, input bit fexp,
                           input int dw, input bit dexp, output bit alive);
        alive = 1'b0;
        t_bus(1'b0, ins, fw, fexp);
        if (fexp) begin
            t_halt(2);
            return;
        end
        t_decode(ins);
        t_exec(ins);
        case (ins.cls)
            CLS_ALU: begin
                t_wb(ins);
                alive = 1'b1;
            end
            CLS_BR: alive = 1'b1;
            CLS_MEM: begin
                t_bus(1'b1, ins, dw, dexp);
                if (dexp) begin
                    t_halt(2);
                end else begin
                    if (!ins.mw) t_wb(ins);
                    alive = 1'b1;
                end
            end
            default: t_halt(2);
        endcase
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        instr_t alu;
        instr_t ld;
        instr_t st;
        instr_t br;
        instr_t rsv;
        instr_t ins;
        in_t    i;
        bit     alive;
        logic [2:0] br_cmp [4] = '{3'b000, 3'b000, 3'b110, 3'b111};
        logic       br_ct  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       br_exp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

        alu = '{cls: CLS_ALU, mw: 1'b0, rw: 1'b1, cmp: 3'b000, ct: 1'b0};
        ld  = '{cls: CLS_MEM, mw: 1'b0, rw: 1'b1, cmp: 3'b000, ct: 1'b0};
        st  = '{cls: CLS_MEM, mw: 1'b1, rw: 1'b1, cmp: 3'b000, ct: 1'b0};
        rsv = '{cls: CLS_RSV, mw: 1'b0, rw: 1'b1, cmp: 3'b000, ct: 1'b0};

        // ALU op with zero-wait memory, then a load with three wait cycles.
        do_reset();
        start_run(0);
        t_bus(1'b0, alu, 0, 1'b0);
        check("alu_ir_load_cycle1", 32'(last.ir_load), 32'd1);
        t_decode(alu);
        t_exec(alu);
        t_wb(alu);
        check("alu_rf_we_cycle4", 32'(last.rf_we), 32'd1);
        check("alu_pc_en_cycle4", 32'(last.pc_en), 32'd1);
        t_bus(1'b0, ld, 0, 1'b0);
        check("alu_retired_one", 32'(last.retired), 32'd1);
        t_decode(ld);
        t_exec(ld);
        t_bus(1'b1, ld, 3, 1'b0);
        check("load_mdr_load", 32'(last.mdr_load), 32'd1);
        check("load_addr_sel", 32'(last.mem_addr_sel), 32'd1);
        t_wb(ld);
        check("load_rf_we", 32'(last.rf_we), 32'd1);

        // Store: write strobe during the access, retire on the acknowledge, no register write.
        t_bus(1'b0, st, 1, 1'b0);
        check("store_retired_two", 32'(last.retired), 32'd2);
        t_decode(st);
        t_exec(st);
        t_bus(1'b1, st, 2, 1'b0);
        check("store_mem_we", 32'(last.mem_we), 32'd1);
        check("store_pc_en", 32'(last.pc_en), 32'd1);
        check("store_rf_we", 32'(last.rf_we), 32'd0);

        for (int k = 0; k < 4; k++) begin
            br = '{cls: CLS_BR, mw: 1'b0, rw: 1'b0, cmp: br_cmp[k], ct: br_ct[k]};
            t_bus(1'b0, br, 0, 1'b0);
            t_decode(br);
            t_exec(br);
            check($sformatf("branch_pc_sel_%0d", k), 32'(last.pc_sel), 32'(br_exp[k]));
        end

        // Fetch never acknowledged: error after the count reaches the limit.
        t_bus(1'b0, alu, TO, 1'b1);
        t_halt(2);
        check("timeout_bus_err", 32'(last.bus_err), 32'd1);
        check("timeout_halted", 32'(last.halted), 32'd1);
        check("timeout_retired_kept", 32'(last.retired), 32'd7);

        // Acknowledge arriving exactly at the limit still completes.
        do_reset();
        start_run(1);
        t_bus(1'b0, alu, TO, 1'b0);
        check("edge_ready_ir_load", 32'(last.ir_load), 32'd1);
        check("edge_ready_no_err", 32'(last.bus_err), 32'd0);
        t_decode(alu);
        t_exec(alu);
        t_wb(alu);

        // Reserved class halts without retiring.
        t_bus(1'b0, rsv, 1, 1'b0);
        t_decode(rsv);
        t_exec(rsv);
        check("rsv_no_pc_en", 32'(last.pc_en), 32'd0);
        t_halt(3);
        check("rsv_illegal", 32'(last.illegal), 32'd1);
        check("rsv_halted", 32'(last.halted), 32'd1);
        check("rsv_retired_one", 32'(last.retired), 32'd1);

        // Reset asserted in the middle of a fetch clears everything at once.
        do_reset();
        start_run(0);
        t_instr(alu, 0, 1'b0, 0, 1'b0, alive);
        i       = rnd_in();
        i.ready = 1'b0;
        drive(i);
        #2;
        check("midfetch_req", 32'(bus.mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midfetch_async_clear", 32'(sample()), 32'd0);
        do_reset();
        start_run(2);
        t_bus(1'b0, alu, 0, 1'b0);
        check("restart_ir_load", 32'(last.ir_load), 32'd1);

        // Randomized programs; long ones wrap the retire counter.
        for (int p = 0; p < 60; p++) begin
            int n_instr;
            do_reset();
            start_run(int'($urandom_range(0, 3)));
            n_instr = int'($urandom_range(5, 30));
            for (int k = 0; k < n_instr; k++) begin
                int r;
                bit fexp;
                bit dexp;
                int fw;
                int dw;
                r       = int'($urandom_range(0, 19));
                ins.cls = (r == 0) ? CLS_RSV : ((r % 3 == 0) ? CLS_MEM : ((r % 3 == 1) ? CLS_ALU : CLS_BR));
                ins.mw  = 1'($urandom);
                ins.rw  = 1'($urandom);
                ins.cmp = 3'($urandom);
                ins.ct  = 1'($urandom);
                fexp    = ($urandom_range(0, 39) == 0);
                dexp    = ($urandom_range(0, 29) == 0);
                fw      = fexp ? TO : int'($urandom_range(0, TO));
                dw      = dexp ? TO : int'($urandom_range(0, TO));
                t_instr(ins, fw, fexp, dw, dexp, alive);
                if (!alive) break;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
